// File: rtl/bus_xfer_pkg.sv
// Shared state type and default sizing for the register-to-register bus transfer sequencer.
package bus_xfer_pkg;

    localparam int DEF_NREG = 16;
    localparam int DEF_DW   = 16;
    localparam int IDX_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SETTLE,
        ST_WRITE,
        ST_DONE
    } xfer_state_t;

endpackage

// File: rtl/reg_sel_dec.sv
// Register index to one-hot strobe decoder; output is all-zero when en is low
// or when idx addresses no implemented register.
module reg_sel_dec
    import bus_xfer_pkg::*;
#(
    parameter int NREG = DEF_NREG
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREG-1:0]  sel
);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREG; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Initiator for single register-to-register moves over the shared data bus.
// Optional immediate-load path (IDLE->WRITE->DONE) is built when XFER_IMM_EN is defined.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int DW   = DEF_DW
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             req,
    input  logic [IDX_W-1:0] src,
    input  logic [IDX_W-1:0] dst,
    input  logic             imm_sel,
    input  logic [DW-1:0]    imm,
    input  logic [DW-1:0]    bus_in,
    output logic [NREG-1:0]  ldbus,
    output logic [NREG-1:0]  wr,
    output logic [DW-1:0]    bus_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    xfer_state_t      state;
    xfer_state_t      state_nxt;
    logic [IDX_W-1:0] src_q;
    logic [IDX_W-1:0] dst_q;
    logic [DW-1:0]    hold;
    logic             err_q;
    logic             accept;
    logic             src_bad;
    logic             dst_bad;
    logic             imm_req;
    logic             reject;
    logic             ld_en;
    logic             wr_en;

    assign accept  = (state == ST_IDLE) && req;
    assign src_bad = int'(src) >= NREG;
    assign dst_bad = int'(dst) >= NREG;

`ifdef XFER_IMM_EN
    assign imm_req = imm_sel;
`else
    logic unused_imm;
    assign imm_req    = 1'b0;
    assign unused_imm = ^{imm_sel, imm};
`endif

    // An immediate load never touches the source register, so its index is not checked.
    assign reject = dst_bad || (src_bad && !imm_req);

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            err_q <= accept && reject;
            if (state == ST_SETTLE) begin
                hold <= bus_in;
            end
`ifdef XFER_IMM_EN
            else if (accept && imm_req && !reject) begin
                hold <= imm;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            src_q <= src;
            dst_q <= dst;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        ld_en     = 1'b0;
        wr_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept && !reject) begin
                    state_nxt = imm_req ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                ld_en     = 1'b1;
                state_nxt = ST_SETTLE;
            end
            // Source keeps driving so bus_in is stable when hold captures it.
            ST_SETTLE: begin
                ld_en     = 1'b1;
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en     = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    reg_sel_dec #(.NREG(NREG)) u_ld_dec (
        .idx (src_q),
        .en  (ld_en),
        .sel (ldbus)
    );

    reg_sel_dec #(.NREG(NREG)) u_wr_dec (
        .idx (dst_q),
        .en  (wr_en),
        .sel (wr)
    );

    assign bus_out = hold;
    assign err     = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a 16-register and an 8-register instance share the same stimulus,
// each with its own register bank; outputs are compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_bus_xfer_ctrl;

    localparam int DW = 16;
`ifdef XFER_IMM_EN
    localparam bit IMM_ON = 1'b1;
`else
    localparam bit IMM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          RST;
    logic          req;
    logic          imm_sel;
    logic [3:0]    src;
    logic [3:0]    dst;
    logic [DW-1:0] imm;
    logic [DW-1:0] bus_in_a, bus_in_b, bus_out_a, bus_out_b;
    logic [15:0]   ldbus_a, wr_a;
    logic [7:0]    ldbus_b, wr_b;
    logic          busy_a, done_a, err_a, busy_b, done_b, err_b;

    logic [DW-1:0] bank [2][16];

    bus_xfer_ctrl #(.NREG(16), .DW(DW)) u_dut (
        .clk(clk), .RST(RST), .req(req), .src(src), .dst(dst),
        .imm_sel(imm_sel), .imm(imm), .bus_in(bus_in_a),
        .ldbus(ldbus_a), .wr(wr_a), .bus_out(bus_out_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    bus_xfer_ctrl #(.NREG(8), .DW(DW)) u_dut8 (
        .clk(clk), .RST(RST), .req(req), .src(src), .dst(dst),
        .imm_sel(imm_sel), .imm(imm), .bus_in(bus_in_b),
        .ldbus(ldbus_b), .wr(wr_b), .bus_out(bus_out_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always_comb begin
        bus_in_a = '0;
        for (int i = 0; i < 16; i++) if (ldbus_a[i]) bus_in_a = bus_in_a | bank[0][i];
    end

    always_comb begin
        bus_in_b = '0;
        for (int i = 0; i < 8; i++) if (ldbus_b[i]) bus_in_b = bus_in_b | bank[1][i];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Transaction model: a move is a timeline of cycles counted from the accept edge.
    bit            m_act [2];
    int            m_k   [2];
    bit            m_imm [2];
    int            m_src [2];
    int            m_dst [2];
    bit            m_err [2];
    logic [DW-1:0] m_val [2];
    logic [DW-1:0] m_out [2];
    logic [DW-1:0] mreg  [2][16];

    function automatic int nreg(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    task automatic model_step(input int d);
        int wk, len;
        bit use_imm, bad;
        wk  = m_imm[d] ? 1 : 3;
        len = m_imm[d] ? 2 : 4;
        m_err[d] = 1'b0;
        if (m_act[d] && m_k[d] == wk) mreg[d][m_dst[d]] = m_val[d];
        if (RST) begin
            m_act[d] = 1'b0;
            m_out[d] = '0;
        end else if (m_act[d]) begin
            if (m_k[d] == len) m_act[d] = 1'b0;
            else begin
                m_k[d]++;
                if (m_k[d] == wk) m_out[d] = m_val[d];
            end
        end else if (req) begin
            use_imm = IMM_ON && imm_sel;
            bad = (int'(dst) >= nreg(d)) || (!use_imm && int'(src) >= nreg(d));
            if (bad) m_err[d] = 1'b1;
            else begin
                m_act[d] = 1'b1;
                m_k[d]   = 1;
                m_imm[d] = use_imm;
                m_src[d] = int'(src);
                m_dst[d] = int'(dst);
                m_val[d] = use_imm ? imm : mreg[d][src];
                if (use_imm) m_out[d] = imm;
            end
        end
    endtask

    task automatic compare(input int d);
        int wk, len;
        logic [15:0] e_ld, e_wr, g_ld, g_wr;
        wk   = m_imm[d] ? 1 : 3;
        len  = m_imm[d] ? 2 : 4;
        e_ld = (m_act[d] && !m_imm[d] && m_k[d] <= 2) ? (16'd1 << m_src[d]) : 16'd0;
        e_wr = (m_act[d] && m_k[d] == wk) ? (16'd1 << m_dst[d]) : 16'd0;
        g_ld = (d == 0) ? ldbus_a : {8'h00, ldbus_b};
        g_wr = (d == 0) ? wr_a : {8'h00, wr_b};
        check_val($sformatf("ldbus[%0d]", d), 32'(g_ld), 32'(e_ld));
        check_val($sformatf("wr[%0d]", d), 32'(g_wr), 32'(e_wr));
        check_val($sformatf("bus_out[%0d]", d), 32'((d == 0) ? bus_out_a : bus_out_b), 32'(m_out[d]));
        check_val($sformatf("busy[%0d]", d), 32'((d == 0) ? busy_a : busy_b), 32'(m_act[d]));
        check_val($sformatf("done[%0d]", d), 32'((d == 0) ? done_a : done_b),
                  32'(m_act[d] && m_k[d] == len));
        check_val($sformatf("err[%0d]", d), 32'((d == 0) ? err_a : err_b), 32'(m_err[d]));
    endtask

    task automatic tick();
        logic [15:0]   wa;
        logic [7:0]    wb;
        logic [DW-1:0] va, vb;
        wa = wr_a;
        wb = wr_b;
        va = bus_out_a;
        vb = bus_out_b;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) if (wa[i] === 1'b1) bank[0][i] = va;
        for (int i = 0; i < 8; i++)  if (wb[i] === 1'b1) bank[1][i] = vb;
        model_step(0);
        model_step(1);
        compare(0);
        compare(1);
    endtask

    task automatic preload(input int idx, input logic [DW-1:0] val);
        bank[0][idx] = val;
        mreg[0][idx] = val;
        bank[1][idx] = val;
        mreg[1][idx] = val;
    endtask

    initial begin
        int starts[$];
        int ndone;
        bit prev_busy;

        RST = 1'b1; req = 1'b0; src = '0; dst = '0; imm_sel = 1'b0; imm = '0;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0; m_k[d] = 0; m_imm[d] = 1'b0; m_src[d] = 0; m_dst[d] = 0;
            m_err[d] = 1'b0; m_val[d] = '0; m_out[d] = '0;
        end
        for (int i = 0; i < 16; i++) preload(i, DW'($urandom));

        tick(); tick();
        check_val("rst_ldbus", 32'(ldbus_a), 32'h0);
        check_val("rst_wr", 32'(wr_a), 32'h0);
        check_val("rst_bus_out", 32'(bus_out_a), 32'h0);
        check_val("rst_busy_done_err", 32'({busy_a, done_a, err_a}), 32'h0);
        RST = 1'b0;
        tick();

        // basic move 3 -> 7
        preload(3, 16'hA5C3);
        req = 1'b1; src = 4'd3; dst = 4'd7; tick(); req = 1'b0;
        check_val("mv_ld_n1", 32'(ldbus_a), 32'h0008);
        tick(); check_val("mv_ld_n2", 32'(ldbus_a), 32'h0008);
        tick(); check_val("mv_wr_n3", 32'(wr_a), 32'h0080);
        check_val("mv_bus_n3", 32'(bus_out_a), 32'hA5C3);
        tick(); check_val("mv_done_n4", 32'(done_a), 32'h1);
        tick();

        // req held for 10 cycles: accepts only at offsets 0 and 5
        req = 1'b1; src = 4'd1; dst = 4'd2; ndone = 0;
        for (int c = 0; c < 15; c++) begin
            if (c == 10) req = 1'b0;
            prev_busy = busy_a;
            tick();
            if (busy_a && !prev_busy) starts.push_back(c);
            if (done_a) ndone++;
        end
        check_val("hold_req_starts", 32'(starts.size()), 32'd2);
        if (starts.size() == 2) begin
            check_val("hold_req_first", 32'(starts[0]), 32'd0);
            check_val("hold_req_second", 32'(starts[1]), 32'd5);
        end
        check_val("hold_req_dones", 32'(ndone), 32'd2);

        // dst out of range for the 8-register instance
        req = 1'b1; src = 4'd2; dst = 4'd9; tick(); req = 1'b0;
        check_val("range_err", 32'(err_b), 32'h1);
        check_val("range_busy", 32'(busy_b), 32'h0);
        check_val("range_ld", 32'({ldbus_b, wr_b}), 32'h0);
        tick(); check_val("range_err_pulse", 32'(err_b), 32'h0);
        repeat (4) tick();

        // immediate request
        req = 1'b1; imm_sel = 1'b1; imm = 16'h1234; src = 4'd4; dst = 4'd15; tick();
        req = 1'b0; imm_sel = 1'b0;
`ifdef XFER_IMM_EN
        check_val("imm_wr", 32'(wr_a), 32'h8000);
        check_val("imm_bus", 32'(bus_out_a), 32'h1234);
        check_val("imm_ld", 32'(ldbus_a), 32'h0);
        tick(); check_val("imm_done", 32'(done_a), 32'h1);
`else
        check_val("noimm_ld", 32'(ldbus_a), 32'h0010);
        tick(); tick();
        check_val("noimm_wr", 32'(wr_a), 32'h8000);
        check_val("noimm_bus", 32'(bus_out_a), 32'(mreg[0][4]));
        tick(); check_val("noimm_done", 32'(done_a), 32'h1);
`endif
        tick();

        // reset during SETTLE
        req = 1'b1; src = 4'd6; dst = 4'd1; tick(); req = 1'b0;
        tick();
        RST = 1'b1; tick(); RST = 1'b0;
        check_val("midrst_outs", 32'({ldbus_a, wr_a}), 32'h0);
        check_val("midrst_bus", 32'(bus_out_a), 32'h0);
        check_val("midrst_flags", 32'({busy_a, done_a, err_a}), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("midrst_quiet", 32'({wr_a, done_a}), 32'h0);
        end

        // src == dst
        preload(5, 16'hFFFF);
        req = 1'b1; src = 4'd5; dst = 4'd5; tick(); req = 1'b0;
        tick(); tick();
        check_val("self_wr", 32'(wr_a), 32'h0020);
        check_val("self_bus", 32'(bus_out_a), 32'hFFFF);
        tick(); check_val("self_done", 32'(done_a), 32'h1);
        tick();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            req     = ($urandom_range(0, 2) == 0);
            src     = 4'($urandom_range(0, 15));
            dst     = 4'($urandom_range(0, 15));
            imm_sel = 1'($urandom_range(0, 1));
            imm     = DW'($urandom);
            RST     = ($urandom_range(0, 59) == 0);
            tick();
        end
        RST = 1'b0; req = 1'b0;
        repeat (6) tick();

        for (int i = 0; i < 16; i++) check_val($sformatf("bank16_%0d", i), 32'(bank[0][i]), 32'(mreg[0][i]));
        for (int i = 0; i < 8; i++)  check_val($sformatf("bank8_%0d", i), 32'(bank[1][i]), 32'(mreg[1][i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
